// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the shared 3-bit adder arbiter.
// Imported by the arbiter, the top and the bench.
package adder_arb_pkg;

   localparam int ADD_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request after ptr, cyclically.
// Produces a one-hot grant and its index.
import adder_arb_pkg::*;

module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [id_w(NREQ)-1:0]   ptr,
   output logic [NREQ-1:0]         gnt,
   output logic [id_w(NREQ)-1:0]   gnt_idx
);

   localparam int ID_W = id_w(NREQ);

   logic w_hit;
   int   w_j;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      w_hit   = 1'b0;
      w_j     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_j = (int'(ptr) + k) % NREQ;
         if (!w_hit && req[w_j]) begin
            w_hit      = 1'b1;
            gnt[w_j]   = 1'b1;
            gnt_idx    = ID_W'(w_j);
         end
      end
   end

endmodule

// File: rtl/threebit.sv
// Plain 3-bit combinational adder, no carry-in.
// Shared datapath element.
module threebit (
   input  logic [2:0] a,
   input  logic [2:0] b,
   output logic [2:0] s,
   output logic       cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_share_arb.sv
// One 3-bit adder shared by NREQ requesters through a round-robin
// arbiter; tagged response channel and saturating carry-out counter.
import adder_arb_pkg::*;

module adder_share_arb #(
   parameter int NREQ  = 2,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*3-1:0]       req_a,
   input  logic [NREQ*3-1:0]       req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [2:0]              rsp_sum,
   output logic                    rsp_cout,
   output logic [CNT_W-1:0]        cout_cnt
);

   localparam int ID_W = id_w(NREQ);

   state_t             r_state;
   logic [ID_W-1:0]    r_ptr;
   logic [ID_W-1:0]    r_id;
   logic [ADD_W-1:0]   r_a;
   logic [ADD_W-1:0]   r_b;
   logic               r_valid;
   logic [ID_W-1:0]    r_rsp_id;
   logic [ADD_W-1:0]   r_sum;
   logic               r_cout;
   logic [CNT_W-1:0]   r_cnt;

   logic [NREQ-1:0]    w_gnt;
   logic [ID_W-1:0]    w_gidx;
   logic [ADD_W-1:0]   w_a;
   logic [ADD_W-1:0]   w_b;
   logic [ADD_W-1:0]   w_s;
   logic               w_cout;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req     (req_valid),
      .ptr     (r_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gidx)
   );

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_a = req_a[i*ADD_W +: ADD_W];
            w_b = req_b[i*ADD_W +: ADD_W];
         end
      end
   end

   threebit u_add (
      .a    (r_a),
      .b    (r_b),
      .s    (w_s),
      .cout (w_cout)
   );

   // Gated by rst_n so no grant is visible while reset is held.
   assign req_ready = (rst_n && r_state == IDLE) ? w_gnt : '0;
   assign rsp_valid = r_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_sum   = r_sum;
   assign rsp_cout  = r_cout;
   assign cout_cnt  = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_ptr    <= ID_W'(NREQ - 1);
         r_id     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_valid  <= 1'b0;
         r_rsp_id <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
         r_cnt    <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (|w_gnt) begin
                  r_a     <= w_a;
                  r_b     <= w_b;
                  r_id    <= w_gidx;
                  r_ptr   <= w_gidx;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_sum    <= w_s;
               r_cout   <= w_cout;
               r_rsp_id <= r_id;
               r_valid  <= 1'b1;
               if (w_cout && r_cnt != '1)
                  r_cnt <= r_cnt + CNT_W'(1);
               r_state  <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed plus randomized bench for adder_share_arb (NREQ=3, CNT_W=2)
// against an arithmetic round-robin reference model.
module tb_adder_share_arb;

   localparam int N  = 3;
   localparam int CW = 2;
   localparam int IW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*3-1:0] req_a;
   logic [N*3-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready = 1'b0;
   logic [IW-1:0]  rsp_id;
   logic [2:0]     rsp_sum;
   logic           rsp_cout;
   logic [CW-1:0]  cout_cnt;

   logic [2:0] ta [N];
   logic [2:0] tb [N];

   assign req_a = {ta[2], ta[1], ta[0]};
   assign req_b = {tb[2], tb[1], tb[0]};

   int    tests = 0;
   int    fails = 0;
   int    mptr  = N - 1;
   int    mcnt  = 0;
   string step  = "init";

   adder_share_arb #(.NREQ(N), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .cout_cnt  (cout_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s/%s observed=%0d expected=%0d",
                step, tag, obs, exp);
      end
   endtask

   function automatic int mgrant(input logic [N-1:0] m, input int p);
      for (int k = 1; k <= N; k++) begin
         if (m[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic set_op(input int i, input int a, input int b);
      ta[i] = 3'(a);
      tb[i] = 3'(b);
   endtask

   task automatic model_reset();
      mptr = N - 1;
      mcnt = 0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_valid", 32'(rsp_valid), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_sum", 32'(rsp_sum), 0);
      chk("rst_cout", 32'(rsp_cout), 0);
      chk("rst_cnt", 32'(cout_cnt), 0);
   endtask

   // Called at posedge+1 in IDLE with req_valid/operands already driven.
   task automatic run_op(input int hold);
      int g;
      int s;
      rsp_ready = (hold == 0);
      #1;
      g = mgrant(req_valid, mptr);
      if (g < 0) begin
         chk("no_grant", 32'(req_ready), 0);
         return;
      end
      chk("grant", 32'(req_ready), 32'(1 << g));
      @(posedge clk);
      s = int'(ta[g]) + int'(tb[g]);
      mptr = g;
      if (s >= 8 && mcnt < CMAX) mcnt++;
      #1;
      chk("exec_ready", 32'(req_ready), 0);
      chk("exec_valid", 32'(rsp_valid), 0);
      @(posedge clk);
      #1;
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_id", 32'(rsp_id), 32'(g));
      chk("rsp_sum", 32'(rsp_sum), 32'(s % 8));
      chk("rsp_cout", 32'(rsp_cout), 32'(s / 8));
      chk("cout_cnt", 32'(cout_cnt), 32'(mcnt));
      chk("resp_ready", 32'(req_ready), 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(rsp_valid), 1);
         chk("hold_id", 32'(rsp_id), 32'(g));
         chk("hold_sum", 32'(rsp_sum), 32'(s % 8));
         chk("hold_cout", 32'(rsp_cout), 32'(s / 8));
         chk("hold_ready", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("consumed", 32'(rsp_valid), 0);
      rsp_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) set_op(i, 0, 0);
      #2 rst_n = 1'b0;
      req_valid = 3'b011;
      #1;
      step = "reset";
      chk_reset_vals();
      @(posedge clk);
      @(posedge clk);
      #1;
      req_valid = '0;
      rst_n = 1'b1;
      model_reset();

      step = "t1";
      set_op(0, 6, 1);
      req_valid = 3'b001;
      run_op(0);
      chk("t1_cnt", 32'(cout_cnt), 0);

      step = "t2a";
      req_valid = 3'b010;
      set_op(1, 2, 3);
      run_op(0);
      step = "t2b";
      req_valid = 3'b001;
      set_op(0, 5, 4);
      run_op(0);
      chk("t2_cnt", 32'(cout_cnt), 1);

      step = "t4_bp";
      req_valid = 3'b011;
      set_op(0, 3, 6);
      set_op(1, 7, 2);
      run_op(5);

      step = "t3";
      rst_n = 1'b0;
      #1;
      chk_reset_vals();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      req_valid = 3'b011;
      set_op(0, 7, 7);
      set_op(1, 1, 1);
      for (int i = 0; i < 3; i++) begin
         run_op(0);
         chk("t3_order", 32'(rsp_id), 32'(i % 2));
      end

      step = "t5_sat";
      req_valid = 3'b001;
      set_op(0, 4, 4);
      for (int i = 0; i < 4; i++) run_op(i % 2);
      chk("t5_cnt", 32'(cout_cnt), CMAX);

      step = "rand";
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < N; i++)
            set_op(i, $urandom_range(0, 7), $urandom_range(0, 7));
         req_valid = 3'($urandom_range(1, 7));
         run_op($urandom_range(0, 2));
      end

      step = "t6_exec";
      req_valid = 3'b100;
      set_op(2, 7, 5);
      #1;
      chk("t6e_grant", 32'(req_ready), 32'(1 << mgrant(req_valid, mptr)));
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk_reset_vals();
      req_valid = '0;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("t6e_quiet", 32'(rsp_valid), 0);
      end
      req_valid = 3'b011;
      set_op(0, 2, 2);
      set_op(1, 6, 6);
      run_op(0);
      chk("t6e_fresh_id", 32'(rsp_id), 0);

      step = "t6_resp";
      req_valid = 3'b010;
      set_op(1, 5, 5);
      #1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("t6r_valid", 32'(rsp_valid), 1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals();
      req_valid = '0;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("t6r_quiet", 32'(rsp_valid), 0);
      end
      req_valid = 3'b111;
      set_op(0, 1, 2);
      run_op(1);
      chk("t6r_fresh_id", 32'(rsp_id), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
